dds_wave_gen: RTL and testbench

DDS_WAVE_GEN -- requirements
Module: dds_wave_gen

---
 rtl/awg_pkg.sv | 9 +
 rtl/sine_table.sv | 39 +++
 rtl/dds_wave_gen.sv | 114 +++++++++++
 tb/tb_dds_wave_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// awg_pkg: waveform mode encodings and default widths shared by the DDS generator
package awg_pkg;
    typedef enum logic [1:0] {WAVE_SAW, WAVE_TRI, WAVE_SQR, WAVE_SIN} wave_e;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_DAC_W  = 14;
    localparam int DEF_LUT_AW = 10;
    localparam int DEF_PH_W   = 8;
    localparam int DEF_AMP_W  = 8;
endpackage

// File: rtl/sine_table.sv
// sine_table: one-period offset-binary sine ROM with a registered read
// Ports: clk - read clock; addr - table index; data - sample, valid one cycle after addr
module sine_table
    import awg_pkg::*;
#(
    parameter int AW = DEF_LUT_AW,
    parameter int DW = DEF_DAC_W
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);
    localparam int N = 2 ** AW;
    localparam int Q = N / 4;
    // Fixed-point (2^30) Taylor series on the first quadrant, mirrored and negated for the rest.
    function automatic logic [DW-1:0] sine_at(input int i);
        longint one, x, x2, term, sum, mag, mid;
        int k;
        one = 64'sd1 <<< 30;
        mid = 64'sd1 <<< (DW - 1);
        k = ((i / Q) % 2 == 1) ? Q - (i % Q) : i % Q;
        x = longint'(k) * 64'sd1686629713 / Q;
        x2 = x * x / one;
        term = x;
        sum = x;
        for (int n = 1; n < 8; n++) begin
            term = -term * x2 / one / (2 * n * (2 * n + 1));
            sum += term;
        end
        mag = (sum * (mid - 1) + one / 2) / one;
        return (i >= N / 2) ? DW'(mid - mag) : DW'(mid + mag);
    endfunction
    logic [DW-1:0] rom [N];
    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic [DW-1:0] V = sine_at(g);
        assign rom[g] = V;
    end
    always_ff @(posedge clk) data <= rom[addr];
endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform generator with handshaked config and amplitude scaling
// Ports: clk/rst_n - clock, async active-low reset; en - run; sync - phase restart;
//        cfg_valid/cfg_ready + cfg_freq/cfg_phase/cfg_amp/cfg_mode - config offer;
//        dac_data/dac_valid - offset-binary output sample and its live flag
module dds_wave_gen
    import awg_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DAC_W  = DEF_DAC_W,
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int PH_W   = DEF_PH_W,
    parameter int AMP_W  = DEF_AMP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_freq,
    input  logic [PH_W-1:0]  cfg_phase,
    input  logic [AMP_W-1:0] cfg_amp,
    input  logic [1:0]       cfg_mode,
    output logic [DAC_W-1:0] dac_data,
    output logic             dac_valid
);
    localparam int SW = DAC_W + 1;
    localparam int PW = DAC_W + AMP_W + 2;
    localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};
    logic [ACC_W-1:0] acc, freq, pend_freq;
    logic [PH_W-1:0]  phase, pend_phase;
    logic [AMP_W-1:0] amp, pend_amp, amp1, amp2;
    wave_e            mode, pend_mode, mode1, mode2;
    logic             pend_v, v1, v2, apply, take;
    logic [ACC_W:0]   sum;
    logic [SW-1:0]    p1;
    logic [DAC_W-1:0] raw, raw2, rom_q, r2, scaled;
    logic signed [PW-1:0] diff, prod;
    assign sum       = {1'b0, acc} + {1'b0, freq};
    assign cfg_ready = !pend_v;
    assign take      = cfg_valid && cfg_ready;
    // A pending config lands on the first wrap, any idle cycle, or a sync.
    assign apply     = pend_v && (sync || !en || sum[ACC_W]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            freq       <= '0;
            phase      <= '0;
            amp        <= '1;
            mode       <= WAVE_SAW;
            pend_v     <= 1'b0;
            pend_freq  <= '0;
            pend_phase <= '0;
            pend_amp   <= '0;
            pend_mode  <= WAVE_SAW;
        end else begin
            acc    <= sync ? '0 : en ? sum[ACC_W-1:0] : acc;
            pend_v <= take ? 1'b1 : apply ? 1'b0 : pend_v;
            if (apply) begin
                freq  <= pend_freq;
                phase <= pend_phase;
                amp   <= pend_amp;
                mode  <= pend_mode;
            end
            if (take) begin
                pend_freq  <= cfg_freq;
                pend_phase <= cfg_phase;
                pend_amp   <= cfg_amp;
                pend_mode  <= wave_e'(cfg_mode);
            end
        end
    end
    // Stage 1 snapshots the phase together with the config that belongs to this acc value,
    // so a sample never mixes old and new mode/amp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1    <= '0;
            mode1 <= WAVE_SAW;
            amp1  <= '0;
            v1    <= 1'b0;
            raw2  <= '0;
            mode2 <= WAVE_SAW;
            amp2  <= '0;
            v2    <= 1'b0;
            dac_data  <= MID;
            dac_valid <= 1'b0;
        end else begin
            p1    <= SW'((acc + {phase, {(ACC_W-PH_W){1'b0}}}) >> (ACC_W - SW));
            mode1 <= mode;
            amp1  <= amp;
            v1    <= en;
            raw2  <= raw;
            mode2 <= mode1;
            amp2  <= amp1;
            v2    <= v1;
            dac_data  <= v2 ? scaled : MID;
            dac_valid <= v2;
        end
    end
    always_comb begin
        raw = mode1 == WAVE_SAW ? p1[DAC_W:1] :
              mode1 == WAVE_TRI ? (p1[DAC_W] ? ~p1[DAC_W-1:0] : p1[DAC_W-1:0]) :
              {DAC_W{~p1[DAC_W]}};
        r2     = mode2 == WAVE_SIN ? rom_q : raw2;
        diff   = PW'(r2) - PW'(MID);
        prod   = diff * $signed(PW'(amp2));
        scaled = MID + DAC_W'(prod >>> AMP_W);
    end
    sine_table #(.AW(LUT_AW), .DW(DAC_W)) u_sine (
        .clk  (clk),
        .addr (p1[DAC_W -: LUT_AW]),
        .data (rom_q)
    );
endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed vector bench for dds_wave_gen at default parameters
module tb_dds_wave_gen;
    import awg_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sync = 1'b0, cfg_valid = 1'b0;
    logic cfg_ready, dac_valid;
    logic [23:0] cfg_freq = '0;
    logic [7:0]  cfg_phase = '0, cfg_amp = '0;
    logic [1:0]  cfg_mode = '0;
    logic [13:0] dac_data;
    int n_cmp = 0, n_bad = 0;
    typedef struct {int grp; int idx; int exp;} vec_t;
    vec_t vecs[19];
    always #5 clk = ~clk;
    dds_wave_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_freq(cfg_freq), .cfg_phase(cfg_phase), .cfg_amp(cfg_amp), .cfg_mode(cfg_mode),
        .dac_data(dac_data), .dac_valid(dac_valid)
    );
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic offer(input int f, input int ph, input int a, input wave_e m);
        cfg_freq  = 24'(f);
        cfg_phase = 8'(ph);
        cfg_amp   = 8'(a);
        cfg_mode  = m;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask
    task automatic setup(input int f, input int a, input wave_e m);
        en = 1'b0;
        offer(f, 0, a, m);
        chk("setup_ready_low", int'(cfg_ready), 0);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        chk("setup_ready_high", int'(cfg_ready), 1);
    endtask
    task automatic run_group(input int g);
        int cur;
        cur = 0;
        en = 1'b1;
        tick(3);
        chk($sformatf("grp%0d_valid_on", g), int'(dac_valid), 1);
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].grp == g) begin
                tick(vecs[i].idx - cur);
                cur = vecs[i].idx;
                chk($sformatf("grp%0d_idx%0d", g, cur), int'(dac_data), vecs[i].exp);
            end
        end
    endtask
    initial begin
        vecs = '{
            '{0, 0, 32}, '{0, 1, 47}, '{0, 2, 63}, '{0, 3, 79},
            '{0, 512, 8192}, '{0, 1023, 16336}, '{0, 1024, 32},
            '{1, 0, 12287}, '{1, 7, 12287}, '{1, 8, 4096}, '{1, 15, 4096}, '{1, 16, 12287},
            '{2, 0, 32}, '{2, 1, 2072}, '{2, 8, 16351}, '{2, 12, 8191},
            '{3, 0, 8192}, '{3, 4, 16351}, '{3, 12, 32}
        };
        tick(2);
        chk("reset_data", int'(dac_data), 8192);
        chk("reset_valid", int'(dac_valid), 0);
        chk("reset_ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        // Saw, freq 16384, amp 255: step ~16, period 1024 clocks.
        setup(16384, 255, WAVE_SAW);
        run_group(0);
        // Square, freq 2^20, amp 128: 8 clocks high, 8 low.
        setup(1 << 20, 128, WAVE_SQR);
        run_group(1);
        // acc is 3 steps of 2^20 here; offer 2^21 and wait for the wrap.
        offer(1 << 21, 0, 128, WAVE_SQR);
        chk("midper_ready_low", int'(cfg_ready), 0);
        tick(11);
        chk("prewrap_ready_low", int'(cfg_ready), 0);
        tick(1);
        chk("postwrap_ready_high", int'(cfg_ready), 1);
        tick(6);
        chk("newstep_hi", int'(dac_data), 12287);
        tick(1);
        chk("newstep_lo", int'(dac_data), 4096);
        // Sync with a pending saw config.
        offer(1 << 20, 0, 255, WAVE_SAW);
        chk("sync_pend_ready_low", int'(cfg_ready), 0);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        chk("sync_ready_high", int'(cfg_ready), 1);
        tick(3);
        chk("sync_acc0", int'(dac_data), 32);
        tick(1);
        chk("sync_acc1", int'(dac_data), 1052);
        // en low for 5 cycles with acc held at 4 steps.
        en = 1'b0;
        tick(2);
        chk("drop_valid_still", int'(dac_valid), 1);
        tick(1);
        chk("drop_valid_low", int'(dac_valid), 0);
        chk("drop_data_mid", int'(dac_data), 8192);
        tick(2);
        en = 1'b1;
        tick(2);
        chk("resume_valid_pending", int'(dac_valid), 0);
        tick(1);
        chk("resume_valid", int'(dac_valid), 1);
        chk("resume_acc4", int'(dac_data), 4112);
        tick(1);
        chk("resume_acc5", int'(dac_data), 5132);
        // Reset mid-stream with a pending config.
        offer(1 << 22, 64, 128, WAVE_SQR);
        chk("rst_pend_ready_low", int'(cfg_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_data", int'(dac_data), 8192);
        chk("rst_async_valid", int'(dac_valid), 0);
        chk("rst_async_ready", int'(cfg_ready), 1);
        en = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("rst_rel_ready", int'(cfg_ready), 1);
        en = 1'b1;
        tick(3);
        chk("rst_default_cfg", int'(dac_data), 32);
        tick(2);
        chk("rst_freq_zero", int'(dac_data), 32);
        // Triangle and sine at freq 2^20, amp 255.
        setup(1 << 20, 255, WAVE_TRI);
        run_group(2);
        setup(1 << 20, 255, WAVE_SIN);
        run_group(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
